// File: rtl/irq_pkg.sv
// Shared state type and default sizing for the interrupt arbiter and other
// round-robin schedulers in the design.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        SERVICE
    } irq_state_t;

    localparam int NUM_SRC_DEF = 8;
    localparam int ID_W_DEF    = $clog2(NUM_SRC_DEF);

endpackage

// File: rtl/irq_rr_arbiter_rr_pick.sv
// Combinational round-robin finder: returns the first set bit of eligible at or
// above rr_ptr, wrapping around to the lowest set bit when none lies above.
module rr_pick
    import irq_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int ID_W    = ID_W_DEF
) (
    input  logic [NUM_SRC-1:0] eligible,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               found,
    output logic [ID_W-1:0]    index
);

    logic              hi_found;
    logic [ID_W-1:0]   hi_idx;
    logic [ID_W-1:0]   lo_idx;

    // Scan downward so the last hit recorded in each class is its lowest index.
    always_comb begin
        found    = 1'b0;
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                found  = 1'b1;
                lo_idx = ID_W'(i);
                if (ID_W'(i) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                end
            end
        end
        index = hi_found ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/irq_rr_arbiter.sv
// Round-robin interrupt arbiter: edge-captured pending requests, mask, and an
// offer/accept/service handshake. Define IRQ_TIMEOUT_EN to enable the service watchdog.
module irq_rr_arbiter
    import irq_pkg::*;
#(
    parameter int NUM_SRC     = NUM_SRC_DEF,
    parameter int ID_W        = ID_W_DEF,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_req,
    input  logic [NUM_SRC-1:0] irq_mask,
    output logic               irq_valid,
    output logic [ID_W-1:0]    irq_id,
    input  logic               irq_ready,
    input  logic               irq_done,
    output logic               irq_busy,
    output logic [NUM_SRC-1:0] pending,
    output logic               timeout_err
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_SRC - 1);

    irq_state_t         state, state_nxt;
    logic [NUM_SRC-1:0] req_d;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] pending_nxt;
    logic [ID_W-1:0]    rr_ptr, rr_ptr_nxt;
    logic [ID_W-1:0]    sel_id, id_nxt;
    logic               sel_found;
    logic               valid_nxt, busy_nxt;
    logic               accept, withdraw, tmo_hit;

    assign rise     = irq_req & ~req_d;
    assign eligible = pending & ~irq_mask;
    // irq_valid is high exactly while in OFFER, so the state stands in for it here.
    assign accept   = (state == OFFER) && irq_ready;
    assign withdraw = (state == OFFER) && !irq_ready && irq_mask[irq_id];

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_pick (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .found    (sel_found),
        .index    (sel_id)
    );

    always_comb begin
        state_nxt   = state;
        valid_nxt   = irq_valid;
        busy_nxt    = irq_busy;
        id_nxt      = irq_id;
        rr_ptr_nxt  = rr_ptr;
        pending_nxt = pending | rise;
        unique case (state)
            IDLE: begin
                if (sel_found) begin
                    state_nxt = OFFER;
                    valid_nxt = 1'b1;
                    id_nxt    = sel_id;
                end
            end
            OFFER: begin
                if (accept) begin
                    // A fresh rise on the accepted source re-sets its pending bit.
                    pending_nxt = (pending & ~(NUM_SRC'(1) << irq_id)) | rise;
                    rr_ptr_nxt  = (irq_id == LAST_ID) ? '0 : irq_id + ID_W'(1);
                    valid_nxt   = 1'b0;
                    busy_nxt    = 1'b1;
                    state_nxt   = SERVICE;
                end else if (withdraw) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            SERVICE: begin
                if (irq_done || tmo_hit) begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            irq_valid <= 1'b0;
            irq_id    <= '0;
            irq_busy  <= 1'b0;
            pending   <= '0;
            rr_ptr    <= '0;
            req_d     <= '0;
        end else begin
            state     <= state_nxt;
            irq_valid <= valid_nxt;
            irq_id    <= id_nxt;
            irq_busy  <= busy_nxt;
            pending   <= pending_nxt;
            rr_ptr    <= rr_ptr_nxt;
            req_d     <= irq_req;
        end
    end

`ifdef IRQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    logic [CNT_W-1:0] tmo_cnt;

    // Counter sits at zero outside SERVICE, so it starts clean on every entry.
    assign tmo_hit = (state == SERVICE) && !irq_done &&
                     (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo_hit;
            if (state == SERVICE) tmo_cnt <= tmo_cnt + CNT_W'(1);
            else                  tmo_cnt <= '0;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_irq_rr_arbiter.sv
// Directed bench for irq_rr_arbiter: handshake, round-robin order, masking,
// same-cycle re-arm, reset mid-service and (with IRQ_TIMEOUT_EN) the watchdog.
module tb_irq_rr_arbiter;

    localparam int NUM_SRC = 8;
    localparam int ID_W    = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic [NUM_SRC-1:0] irq_req;
    logic [NUM_SRC-1:0] irq_mask;
    logic               irq_valid;
    logic [ID_W-1:0]    irq_id;
    logic               irq_ready;
    logic               irq_done;
    logic               irq_busy;
    logic [NUM_SRC-1:0] pending;
    logic               timeout_err;

    int n_chk  = 0;
    int n_fail = 0;

    irq_rr_arbiter #(
        .NUM_SRC     (NUM_SRC),
        .ID_W        (ID_W),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .irq_req     (irq_req),
        .irq_mask    (irq_mask),
        .irq_valid   (irq_valid),
        .irq_id      (irq_id),
        .irq_ready   (irq_ready),
        .irq_done    (irq_done),
        .irq_busy    (irq_busy),
        .pending     (pending),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!irq_valid && k < max_cyc);
        check(tag, irq_valid, 1);
    endtask

    task automatic accept_now(input string tag);
        irq_ready = 1'b1;
        tick();
        irq_ready = 1'b0;
        check(tag, {irq_busy, irq_valid}, 2'b10);
    endtask

    task automatic serve_done(input string tag);
        tick();
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        check(tag, irq_busy, 0);
    endtask

    initial begin
        logic [ID_W-1:0] order [3];
        logic            early;
        order = '{3'd1, 3'd4, 3'd6};

        reset = 1'b1; irq_req = '0; irq_mask = '0; irq_ready = 1'b0; irq_done = 1'b0;
        tick();
        tick();
        check("rst_outputs", {irq_valid, irq_id, irq_busy, timeout_err}, 0);
        check("rst_pending", pending, 0);
        reset = 1'b0;

        // Single request on source 3: two-cycle latency, accept, done.
        irq_req = 8'h08;
        tick();
        check("t1_pend_set", pending, 8'h08);
        check("t1_no_valid_yet", irq_valid, 0);
        tick();
        check("t1_valid", irq_valid, 1);
        check("t1_id", irq_id, 3);
        accept_now("t1_accept");
        check("t1_pend_clr", pending, 0);
        irq_req = '0;
        serve_done("t1_done");

        // Simultaneous rises on 1, 4, 6 from a fresh pointer.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        irq_req = 8'h52;
        for (int k = 0; k < 3; k++) begin
            wait_valid("t2_valid", 10);
            check("t2_order", irq_id, order[k]);
            accept_now("t2_accept");
            serve_done("t2_done");
        end
        check("t2_pend_empty", pending, 0);
        irq_req = '0;
        tick();
        // Pointer now 7: source 7 must beat source 0.
        irq_req = 8'h81;
        wait_valid("t2_ptr_valid", 10);
        check("t2_ptr7_first", irq_id, 7);
        accept_now("t2_acc7");
        serve_done("t2_done7");
        wait_valid("t2_wrap_valid", 10);
        check("t2_wrap_id0", irq_id, 0);
        accept_now("t2_acc0");
        serve_done("t2_done0");
        irq_req = '0;
        tick();

        // Masked source is captured but not granted until unmasked.
        irq_mask = 8'h04;
        irq_req  = 8'h04;
        tick(); tick(); tick();
        check("t3_masked_pend", pending, 8'h04);
        check("t3_masked_noval", irq_valid, 0);
        irq_mask = '0;
        wait_valid("t3_unmask_valid", 5);
        check("t3_unmask_id", irq_id, 2);
        accept_now("t3_acc2");
        serve_done("t3_done2");
        irq_req = 8'h20;
        wait_valid("t3_off5_valid", 10);
        check("t3_off5_id", irq_id, 5);
        irq_mask = 8'h20;
        tick();
        check("t3_withdraw", irq_valid, 0);
        check("t3_keep_pend", pending, 8'h20);
        tick();
        check("t3_stay_idle", irq_valid, 0);
        irq_mask = '0;
        wait_valid("t3_regrant_valid", 5);
        check("t3_regrant_id", irq_id, 5);
        accept_now("t3_acc5");
        serve_done("t3_done5");
        irq_req = '0;
        tick();

        // Source 0 rises again in its own accept cycle.
        irq_req = 8'h01;
        wait_valid("t4_valid", 10);
        check("t4_id0", irq_id, 0);
        irq_req = 8'h00;
        tick();
        check("t4_hold_offer", {irq_valid, irq_id}, {1'b1, 3'd0});
        irq_req = 8'h01;
        accept_now("t4_accept");
        check("t4_set_wins", pending, 8'h01);
        serve_done("t4_done");
        wait_valid("t4_again_valid", 5);
        check("t4_again_id0", irq_id, 0);
        accept_now("t4_acc_again");
        check("t4_pend_clr", pending, 0);
        serve_done("t4_done_again");
        irq_req = '0;
        tick();

        // Reset mid-service of source 7 with another request waiting.
        irq_req = 8'h80;
        wait_valid("t5_valid", 10);
        check("t5_id7", irq_id, 7);
        accept_now("t5_acc7");
        irq_req = 8'h82;
        tick();
        check("t5_pend1", pending, 8'h02);
        reset   = 1'b1;
        irq_req = '0;
        tick();
        reset = 1'b0;
        check("t5_rst_outputs", {irq_valid, irq_id, irq_busy, timeout_err}, 0);
        check("t5_rst_pending", pending, 0);
        repeat (5) tick();
        check("t5_no_grant", {irq_valid, irq_busy}, 0);
        check("t5_still_empty", pending, 0);
        irq_req = 8'h10;
        wait_valid("t5_new_valid", 10);
        check("t5_new_id4", irq_id, 4);
        accept_now("t5_acc4");
        serve_done("t5_done4");
        irq_req = '0;

        // Service never completes on source 2 while 5 waits.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        irq_req = 8'h24;
        wait_valid("t6_valid", 10);
        check("t6_id2", irq_id, 2);
        accept_now("t6_acc2");
`ifdef IRQ_TIMEOUT_EN
        early = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            early = early | timeout_err;
        end
        check("t6_no_early_tmo", early, 0);
        check("t6_busy_before", irq_busy, 1);
        tick();
        check("t6_tmo_pulse", timeout_err, 1);
        check("t6_busy_drop", irq_busy, 0);
        tick();
        check("t6_tmo_one_cycle", timeout_err, 0);
`else
        early = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            early = early | timeout_err;
        end
        check("t6_no_tmo", early, 0);
        check("t6_still_busy", {irq_busy, irq_valid}, 2'b10);
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        check("t6_done", irq_busy, 0);
`endif
        wait_valid("t6_next_valid", 5);
        check("t6_next_id5", irq_id, 5);
        accept_now("t6_acc5");
        serve_done("t6_done5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/irq_rr_arbiter.md
Name: irq_rr_arbiter

Overview:
- Sits between the MCAC channel/resource event sources and the interrupt_controller's service side.
- Captures rising-edge interrupt requests from NUM_SRC sources into a pending register and applies a mask.
- Grants exactly one source at a time to the single shared service resource using round-robin priority.
- Tracks each grant through offer, accept and service-complete before granting again.

Parameters:
- NUM_SRC, 8, number of request sources (2..32).
- ID_W, 3, width of granted source index; equals $clog2(NUM_SRC).
- TIMEOUT_CYC, 1024, service watchdog limit in clk cycles; used only with IRQ_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- irq_req  input  NUM_SRC  level request lines; a 0->1 transition sets pending.
- irq_mask  input  NUM_SRC  1 = source blocked from arbitration; pending is still captured.
- irq_valid  output  1  grant offered to service side.
- irq_id  output  ID_W  index of offered/serviced source.
- irq_ready  input  1  service side accepts offer when irq_valid && irq_ready.
- irq_done  input  1  single-cycle pulse: service of current irq_id finished.
- irq_busy  output  1  high from accept until done.
- pending  output  NUM_SRC  registered pending vector, for status readback.
- timeout_err  output  1  one-cycle pulse on watchdog expiry; tied 0 without IRQ_TIMEOUT_EN.

Behaviour:
- Reset (synchronous, active-high) clears the following, and any in-flight grant is abandoned without completion:
  - irq_valid=0, irq_id=0, irq_busy=0, pending=0, timeout_err=0.
  - rr_ptr=0, edge-detect history=0, state=IDLE.
- Edge detect: req_d registers irq_req; rise = irq_req & ~req_d. pending |= rise each cycle.
- Eligible = pending & ~irq_mask.
- Round-robin selection:
  - Choose the first eligible index searching upward from rr_ptr, wrapping from NUM_SRC-1 to 0.
  - Selection is combinational and registered into irq_id on entry to OFFER.
- FSM:
  - IDLE: if eligible != 0, go to OFFER next cycle with irq_valid=1 and irq_id=selection. Latency is 2 cycles from the req edge to irq_valid.
  - OFFER: irq_valid held and irq_id stable until irq_ready. On accept:
    - clear pending[irq_id]; rr_ptr = (irq_id+1) mod NUM_SRC;
    - irq_valid=0, irq_busy=1, go to SERVICE.
  - OFFER with mask change: if irq_mask[irq_id] rises while in OFFER, withdraw the offer (irq_valid=0), return to IDLE and keep pending. This is the only allowed valid drop without accept.
  - SERVICE: wait for irq_done. Then irq_busy=0 and go to IDLE; re-arbitration is possible on the next cycle.
- Simultaneous events:
  - A new rise on the same source in the accept cycle: set wins, pending stays 1.
  - irq_done outside SERVICE is ignored.
  - irq_ready while irq_valid=0 is ignored.
- Rises during SERVICE are captured; no request is lost, but repeated rises before service coalesce into one.

Optional Feature:
- IRQ_TIMEOUT_EN defined:
  - A counter runs in SERVICE. When it reaches TIMEOUT_CYC-1 without irq_done: timeout_err pulses 1 cycle, irq_busy=0, go to IDLE.
  - The counter clears on SERVICE entry and on reset.
- Not defined: no counter; timeout_err is constant 0; SERVICE waits indefinitely.

Decomposition:
- Shared package irq_pkg:
  - typedef enum {IDLE, OFFER, SERVICE} irq_state_t;
  - default NUM_SRC and ID_W constants.
- One sub-module, rr_pick: combinational round-robin priority finder (inputs: eligible vector, rr_ptr; outputs: found, index), reusable by other schedulers in the design.

Test Plan:
- Reset then single rise on irq_req[3] -> irq_valid=1, irq_id=3 two cycles later. irq_ready=1 -> pending[3]=0 and irq_busy=1. irq_done -> irq_busy=0.
- Simultaneous rises on sources 1, 4 and 6 with rr_ptr=0, ready always 1, done 2 cycles after each accept -> grant order 1, 4, 6; final rr_ptr=7.
- Masking:
  - irq_mask[2]=1 with rise on 2 -> pending[2]=1 and no grant.
  - Clear mask -> grant id 2.
  - Set mask[5] while offering id 5 -> irq_valid drops, pending[5] stays 1.
- Rise on source 0 in the same cycle its offer is accepted -> pending[0] remains 1, and source 0 is granted again after done.
- Reset asserted during SERVICE of id 7 -> next cycle all outputs 0, pending=0, and no grant until a new rise.
- With IRQ_TIMEOUT_EN and TIMEOUT_CYC=16, accept id 2 and never assert done -> timeout_err pulses once, 16 cycles after accept; irq_busy drops; the next pending source is granted.
